// File: rtl/top_pkg.sv
// Shared TL-UL widths, opcode constants and the control FSM state type
// for the IOPMP blocks.
package top_pkg;

   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_DIW = 1;
   localparam int TL_DUW = 4;
   localparam int TL_SZW = 2;

   // A-channel opcodes
   localparam logic [2:0] Get            = 3'd4;
   localparam logic [2:0] PutFullData    = 3'd0;
   localparam logic [2:0] PutPartialData = 3'd1;

   // D-channel opcodes
   localparam logic [2:0] AccessAck      = 3'd0;
   localparam logic [2:0] AccessAckData  = 3'd1;

   typedef enum logic {
      NO_OP = 1'b0,
      RESP  = 1'b1
   } state_t_control;

   // Only a Get carries a data response; every other opcode gets a plain ack.
   function automatic logic [2:0] resp_opcode(input logic [2:0] a_opcode);
      return (a_opcode == Get) ? AccessAckData : AccessAck;
   endfunction

endpackage

// File: rtl/iopmp_err_responder.sv
// Terminates TL-UL requests denied by the IOPMP checker with a single error
// D beat, and keeps a sticky first-denial record plus a saturating denial count.
module iopmp_err_responder
   import top_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,

   input  logic              block_i,

   input  logic              a_valid_i,
   input  logic [2:0]        a_opcode_i,
   input  logic [TL_SZW-1:0] a_size_i,
   input  logic [TL_AIW-1:0] a_source_i,
   input  logic [TL_AW-1:0]  a_address_i,
   output logic              a_ready_o,

   output logic              d_valid_o,
   output logic [2:0]        d_opcode_o,
   output logic [2:0]        d_param_o,
   output logic [TL_SZW-1:0] d_size_o,
   output logic [TL_AIW-1:0] d_source_o,
   output logic [TL_DIW-1:0] d_sink_o,
   output logic [TL_DW-1:0]  d_data_o,
   output logic [TL_DUW-1:0] d_user_o,
   output logic              d_error_o,
   input  logic              d_ready_i,

   output logic              err_valid_o,
   output logic [TL_AW-1:0]  err_addr_o,
   output logic [TL_AIW-1:0] err_source_o,
   input  logic              err_clear_i,
   output logic [CNT_W-1:0]  err_count_o
);

   state_t_control    state_q, state_d;
   logic [2:0]        d_opcode_q, d_opcode_d;
   logic [TL_SZW-1:0] d_size_q, d_size_d;
   logic [TL_AIW-1:0] d_source_q, d_source_d;
   logic              err_valid_q, err_valid_d;
   logic [TL_AW-1:0]  err_addr_q, err_addr_d;
   logic [TL_AIW-1:0] err_source_q, err_source_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;

   logic a_ready;
   logic accept;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      d_opcode_d   = d_opcode_q;
      d_size_d     = d_size_q;
      d_source_d   = d_source_q;
      err_valid_d  = err_valid_q;
      err_addr_d   = err_addr_q;
      err_source_d = err_source_q;
      err_count_d  = err_count_q;

      // Gating with rst_ni keeps the master from seeing a handshake during reset.
      a_ready = rst_ni & (state_q == NO_OP) & block_i;
      accept  = a_valid_i & a_ready;

      case (state_q)
         NO_OP: begin
            if (accept) begin
               state_d    = RESP;
               d_opcode_d = resp_opcode(a_opcode_i);
               d_size_d   = a_size_i;
               d_source_d = a_source_i;
            end
         end
         RESP: begin
            if (d_ready_i) state_d = NO_OP;
         end
         default: state_d = NO_OP;
      endcase

      // A clear coinciding with an accept re-arms the record with the new request.
      if (accept && (!err_valid_q || err_clear_i)) begin
         err_valid_d  = 1'b1;
         err_addr_d   = a_address_i;
         err_source_d = a_source_i;
      end else if (err_clear_i) begin
         err_valid_d  = 1'b0;
      end

      if (accept && (err_count_q != {CNT_W{1'b1}})) begin
         err_count_d = err_count_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= NO_OP;
         d_opcode_q   <= '0;
         d_size_q     <= '0;
         d_source_q   <= '0;
         err_valid_q  <= 1'b0;
         err_addr_q   <= '0;
         err_source_q <= '0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         d_opcode_q   <= d_opcode_d;
         d_size_q     <= d_size_d;
         d_source_q   <= d_source_d;
         err_valid_q  <= err_valid_d;
         err_addr_q   <= err_addr_d;
         err_source_q <= err_source_d;
         err_count_q  <= err_count_d;
      end
   end

   assign a_ready_o    = a_ready;

   assign d_valid_o    = (state_q == RESP);
   assign d_error_o    = (state_q == RESP);
   assign d_opcode_o   = d_opcode_q;
   assign d_size_o     = d_size_q;
   assign d_source_o   = d_source_q;
   assign d_param_o    = '0;
   assign d_sink_o     = '0;
   assign d_data_o     = '0;
   assign d_user_o     = '0;

   assign err_valid_o  = err_valid_q;
   assign err_addr_o   = err_addr_q;
   assign err_source_o = err_source_q;
   assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_iopmp_err_responder.sv
// Directed bench for iopmp_err_responder: a default-width instance plus a
// CNT_W=2 instance sharing the same stimulus for the saturation scenario.
module tb_iopmp_err_responder;
   import top_pkg::*;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              block_i;
   logic              a_valid_i;
   logic [2:0]        a_opcode_i;
   logic [TL_SZW-1:0] a_size_i;
   logic [TL_AIW-1:0] a_source_i;
   logic [TL_AW-1:0]  a_address_i;
   logic              d_ready_i;
   logic              err_clear_i;

   logic              a_ready_o,   s_a_ready_o;
   logic              d_valid_o,   s_d_valid_o;
   logic [2:0]        d_opcode_o,  s_d_opcode_o;
   logic [2:0]        d_param_o,   s_d_param_o;
   logic [TL_SZW-1:0] d_size_o,    s_d_size_o;
   logic [TL_AIW-1:0] d_source_o,  s_d_source_o;
   logic [TL_DIW-1:0] d_sink_o,    s_d_sink_o;
   logic [TL_DW-1:0]  d_data_o,    s_d_data_o;
   logic [TL_DUW-1:0] d_user_o,    s_d_user_o;
   logic              d_error_o,   s_d_error_o;
   logic              err_valid_o, s_err_valid_o;
   logic [TL_AW-1:0]  err_addr_o,  s_err_addr_o;
   logic [TL_AIW-1:0] err_source_o, s_err_source_o;
   logic [15:0]       err_count_o;
   logic [1:0]        s_err_count_o;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk_i = ~clk_i;

   iopmp_err_responder #(.CNT_W(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .block_i(block_i),
      .a_valid_i(a_valid_i), .a_opcode_i(a_opcode_i), .a_size_i(a_size_i),
      .a_source_i(a_source_i), .a_address_i(a_address_i), .a_ready_o(a_ready_o),
      .d_valid_o(d_valid_o), .d_opcode_o(d_opcode_o), .d_param_o(d_param_o),
      .d_size_o(d_size_o), .d_source_o(d_source_o), .d_sink_o(d_sink_o),
      .d_data_o(d_data_o), .d_user_o(d_user_o), .d_error_o(d_error_o),
      .d_ready_i(d_ready_i), .err_valid_o(err_valid_o), .err_addr_o(err_addr_o),
      .err_source_o(err_source_o), .err_clear_i(err_clear_i), .err_count_o(err_count_o)
   );

   iopmp_err_responder #(.CNT_W(2)) dut_sat (
      .clk_i(clk_i), .rst_ni(rst_ni), .block_i(block_i),
      .a_valid_i(a_valid_i), .a_opcode_i(a_opcode_i), .a_size_i(a_size_i),
      .a_source_i(a_source_i), .a_address_i(a_address_i), .a_ready_o(s_a_ready_o),
      .d_valid_o(s_d_valid_o), .d_opcode_o(s_d_opcode_o), .d_param_o(s_d_param_o),
      .d_size_o(s_d_size_o), .d_source_o(s_d_source_o), .d_sink_o(s_d_sink_o),
      .d_data_o(s_d_data_o), .d_user_o(s_d_user_o), .d_error_o(s_d_error_o),
      .d_ready_i(d_ready_i), .err_valid_o(s_err_valid_o), .err_addr_o(s_err_addr_o),
      .err_source_o(s_err_source_o), .err_clear_i(err_clear_i), .err_count_o(s_err_count_o)
   );

   // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
   task automatic do_reset();
      rst_ni      = 1'b0;
      block_i     = 1'b1;
      a_valid_i   = 1'b1;
      a_opcode_i  = Get;
      a_size_i    = '0;
      a_source_i  = '0;
      a_address_i = '0;
      d_ready_i   = 1'b1;
      err_clear_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      a_valid_i = 1'b0;
      block_i   = 1'b0;
      rst_ni    = 1'b1;
      #1;
   endtask

   // Presents one blocked request and takes the accepting edge; leaves the DUT in RESP.
   task automatic deny(input logic [TL_AW-1:0] addr, input logic [2:0] op,
                       input logic [TL_AIW-1:0] src, input logic [TL_SZW-1:0] sz);
      a_address_i = addr;
      a_opcode_i  = op;
      a_source_i  = src;
      a_size_i    = sz;
      block_i     = 1'b1;
      a_valid_i   = 1'b1;
      @(posedge clk_i);
      #1;
      a_valid_i   = 1'b0;
      block_i     = 1'b0;
      #1;
   endtask

   task automatic drain();
      d_ready_i = 1'b1;
      @(posedge clk_i);
      #2;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; block_i = 1'b1; a_valid_i = 1'b1; d_ready_i = 1'b0;
      err_clear_i = 1'b0; a_opcode_i = Get; a_size_i = '0; a_source_i = '0; a_address_i = '0;
      @(posedge clk_i); #1;
      tests_run++;
      if (a_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_a_ready: got %b want 0", a_ready_o); end
      @(posedge clk_i); #1;
      tests_run++;
      if ({d_valid_o, d_error_o, d_opcode_o, d_size_o, d_source_o} !== '0) begin
         tests_failed++; $display("FAIL reset_d: got v=%b e=%b op=%0d sz=%0d src=%0h want all 0",
                                  d_valid_o, d_error_o, d_opcode_o, d_size_o, d_source_o);
      end
      tests_run++;
      if ({err_valid_o, err_addr_o, err_source_o, err_count_o} !== '0) begin
         tests_failed++; $display("FAIL reset_err: got v=%b a=%0h s=%0h c=%0d want all 0",
                                  err_valid_o, err_addr_o, err_source_o, err_count_o);
      end
   endtask

   task automatic test_get_denied();
      do_reset();
      a_address_i = 32'h0000_0100; a_opcode_i = Get; a_source_i = 8'h05; a_size_i = 2'd2;
      d_ready_i = 1'b1; block_i = 1'b1; a_valid_i = 1'b1;
      #1;
      tests_run++;
      if (a_ready_o !== 1'b1) begin tests_failed++; $display("FAIL get_a_ready: got %b want 1", a_ready_o); end
      @(posedge clk_i); #1;
      a_valid_i = 1'b0; block_i = 1'b0;
      #1;
      tests_run++;
      if (d_valid_o !== 1'b1 || d_error_o !== 1'b1 || d_opcode_o !== AccessAckData) begin
         tests_failed++; $display("FAIL get_d_beat: got v=%b e=%b op=%0d want v=1 e=1 op=1",
                                  d_valid_o, d_error_o, d_opcode_o);
      end
      tests_run++;
      if (d_source_o !== 8'h05 || d_size_o !== 2'd2 || d_data_o !== '0 ||
          d_param_o !== '0 || d_sink_o !== '0 || d_user_o !== '0) begin
         tests_failed++; $display("FAIL get_d_fields: got src=%0h sz=%0d data=%0h want src=5 sz=2 data=0",
                                  d_source_o, d_size_o, d_data_o);
      end
      tests_run++;
      if (err_count_o !== 16'd1 || err_valid_o !== 1'b1 || err_addr_o !== 32'h100 || err_source_o !== 8'h05) begin
         tests_failed++; $display("FAIL get_err: got c=%0d v=%b a=%0h s=%0h want c=1 v=1 a=100 s=5",
                                  err_count_o, err_valid_o, err_addr_o, err_source_o);
      end
      @(posedge clk_i); #1;
      tests_run++;
      if (d_valid_o !== 1'b0) begin tests_failed++; $display("FAIL get_handshake: got d_valid=%b want 0", d_valid_o); end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      do_reset();
      d_ready_i = 1'b0;
      a_address_i = 32'h0000_0200; a_opcode_i = PutFullData; a_source_i = 8'h0A; a_size_i = 2'd3;
      block_i = 1'b1; a_valid_i = 1'b1;
      @(posedge clk_i); #2;
      for (int i = 0; i < 5; i++) begin
         if (d_valid_o !== 1'b1 || d_opcode_o !== AccessAck || d_source_o !== 8'h0A ||
             d_size_o !== 2'd3 || a_ready_o !== 1'b0) bad++;
         @(posedge clk_i); #2;
      end
      tests_run++;
      if (bad != 0) begin tests_failed++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
      tests_run++;
      if (err_count_o !== 16'd1) begin tests_failed++; $display("FAIL bp_count: got %0d want 1", err_count_o); end
      d_ready_i = 1'b1;
      #1;
      tests_run++;
      if (a_ready_o !== 1'b0) begin tests_failed++; $display("FAIL bp_no_accept_on_hs: got a_ready=%b want 0", a_ready_o); end
      @(posedge clk_i); #2;
      tests_run++;
      if (d_valid_o !== 1'b0 || err_count_o !== 16'd1 || a_ready_o !== 1'b1) begin
         tests_failed++; $display("FAIL bp_after_hs: got v=%b c=%0d rdy=%b want v=0 c=1 rdy=1",
                                  d_valid_o, err_count_o, a_ready_o);
      end
      @(posedge clk_i); #2;
      a_valid_i = 1'b0; block_i = 1'b0;
      tests_run++;
      if (d_valid_o !== 1'b1 || err_count_o !== 16'd2) begin
         tests_failed++; $display("FAIL bp_next_accept: got v=%b c=%0d want v=1 c=2", d_valid_o, err_count_o);
      end
      drain();
   endtask

   task automatic test_sticky_record();
      do_reset();
      deny(32'h0000_1000, Get, 8'h11, 2'd2);
      drain();
      deny(32'h0000_2000, PutPartialData, 8'h22, 2'd1);
      tests_run++;
      if (err_addr_o !== 32'h1000 || err_source_o !== 8'h11 || err_count_o !== 16'd2) begin
         tests_failed++; $display("FAIL sticky_hold: got a=%0h s=%0h c=%0d want a=1000 s=11 c=2",
                                  err_addr_o, err_source_o, err_count_o);
      end
      drain();
      err_clear_i = 1'b1;
      deny(32'h0000_3000, Get, 8'h33, 2'd0);
      err_clear_i = 1'b0;
      tests_run++;
      if (err_valid_o !== 1'b1 || err_addr_o !== 32'h3000 || err_source_o !== 8'h33 || err_count_o !== 16'd3) begin
         tests_failed++; $display("FAIL sticky_clear_accept: got v=%b a=%0h s=%0h c=%0d want v=1 a=3000 s=33 c=3",
                                  err_valid_o, err_addr_o, err_source_o, err_count_o);
      end
      drain();
      err_clear_i = 1'b1;
      @(posedge clk_i); #1;
      err_clear_i = 1'b0;
      #1;
      tests_run++;
      if (err_valid_o !== 1'b0 || err_count_o !== 16'd3) begin
         tests_failed++; $display("FAIL sticky_clear_only: got v=%b c=%0d want v=0 c=3", err_valid_o, err_count_o);
      end
   endtask

   task automatic test_passthrough_opcode();
      int bad = 0;
      do_reset();
      block_i = 1'b0; a_valid_i = 1'b1; a_opcode_i = Get; d_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (a_ready_o !== 1'b0) bad++;
         @(posedge clk_i); #1;
         if (d_valid_o !== 1'b0 || err_count_o !== 16'd0) bad++;
      end
      a_valid_i = 1'b0;
      tests_run++;
      if (bad != 0) begin tests_failed++; $display("FAIL passthrough: got %0d bad samples want 0", bad); end
      deny(32'h0000_4000, 3'd7, 8'h07, 2'd1);
      tests_run++;
      if (d_valid_o !== 1'b1 || d_opcode_o !== AccessAck || d_error_o !== 1'b1) begin
         tests_failed++; $display("FAIL bad_opcode: got v=%b op=%0d e=%b want v=1 op=0 e=1",
                                  d_valid_o, d_opcode_o, d_error_o);
      end
      drain();
   endtask

   task automatic test_saturation_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         deny(32'h0000_5000 + 32'(i), PutFullData, 8'(i), 2'd2);
         drain();
      end
      tests_run++;
      if (s_err_count_o !== 2'd3) begin tests_failed++; $display("FAIL sat_count: got %0d want 3", s_err_count_o); end
      tests_run++;
      if (err_count_o !== 16'd5) begin tests_failed++; $display("FAIL wide_count: got %0d want 5", err_count_o); end
      d_ready_i = 1'b0;
      deny(32'h0000_6000, Get, 8'h66, 2'd3);
      tests_run++;
      if (d_valid_o !== 1'b1 || s_d_valid_o !== 1'b1) begin
         tests_failed++; $display("FAIL rst_pre_resp: got v=%b/%b want 1/1", d_valid_o, s_d_valid_o);
      end
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      tests_run++;
      if ({d_valid_o, d_error_o, d_opcode_o, d_size_o, d_source_o, err_valid_o, err_addr_o,
           err_source_o, err_count_o, a_ready_o} !== '0) begin
         tests_failed++; $display("FAIL rst_in_resp: got v=%b e=%b op=%0d c=%0d ev=%b rdy=%b want all 0",
                                  d_valid_o, d_error_o, d_opcode_o, err_count_o, err_valid_o, a_ready_o);
      end
      tests_run++;
      if ({s_d_valid_o, s_err_count_o, s_err_valid_o} !== '0) begin
         tests_failed++; $display("FAIL rst_sat: got v=%b c=%0d ev=%b want all 0",
                                  s_d_valid_o, s_err_count_o, s_err_valid_o);
      end
      rst_ni = 1'b1;
      d_ready_i = 1'b1;
   endtask

   initial begin
      test_reset();
      test_get_denied();
      test_backpressure();
      test_sticky_record();
      test_passthrough_opcode();
      test_saturation_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
